// File: rtl/dport_pkg.sv
// Shared DisplayPort constants: default line geometry and pixel colours.
// Also holds the line-length helper and the lit-pixel test.
package dport_pkg;

  localparam int PAD_DEF   = 240;
  localparam int BLITH_DEF = 800;

  function automatic int line_tot(input int pad, input int blith);
    return 2 * pad + blith;
  endfunction

  localparam int LINE_TOT = line_tot(PAD_DEF, BLITH_DEF);

  localparam logic [23:0] BRIGHT = 24'h00FF00;
  localparam logic [23:0] DARK   = 24'h000000;

  function automatic logic lit(input logic [7:0] g,
                               input logic [7:0] th);
    return g >= th;
  endfunction

endpackage

// File: rtl/dport_pxpack_if.sv
// Pixel-pair input stream, line-start strobe and packed-word output stream.
// slave = packer side, master = source/sink side.
interface dport_pxpack_if;

  logic        dp_pixel_valid;
  logic [47:0] dp_pixel_data;
  logic        dp_pixel_ready;
  logic        dpdmahstart;
  logic        raw_pixel_valid;
  logic [15:0] raw_pixel_data;
  logic        raw_pixel_ready;

  modport slave (
    input  dp_pixel_valid,
    input  dp_pixel_data,
    input  dpdmahstart,
    input  raw_pixel_ready,
    output dp_pixel_ready,
    output raw_pixel_valid,
    output raw_pixel_data
  );

  modport master (
    output dp_pixel_valid,
    output dp_pixel_data,
    output dpdmahstart,
    output raw_pixel_ready,
    input  dp_pixel_ready,
    input  raw_pixel_valid,
    input  raw_pixel_data
  );

endinterface

// File: rtl/dport_pxpack.sv
// Thresholds green pixel pairs into 1-bit pixels, packs 16 per output word.
// Define DPORT_PXPACK_ERRCNT_EN to count truncated lines in err_cnt.
module dport_pxpack
  import dport_pkg::*;
#(
  parameter int          PAD    = PAD_DEF,
  parameter int          BLITH  = BLITH_DEF,
  parameter logic [7:0]  THRESH = 8'h80
) (
  input  logic          dpclk,
  input  logic          reset,
  dport_pxpack_if.slave dp,
  output logic [7:0]    err_cnt
);

  localparam logic [15:0] X_LO  = 16'(PAD);
  localparam logic [15:0] X_HI  = 16'(PAD + BLITH);
  localparam logic [15:0] X_END = 16'(line_tot(PAD, BLITH) - 2);

  logic        active;
  logic [15:0] x;
  logic [2:0]  pk_cnt;
  logic [13:0] pack;
  logic        raw_v;
  logic [15:0] raw_d;
  logic        in_act;
  logic        stall;
  logic        acc;
  logic [1:0]  pair_bits;
  logic        px_unused;

  assign in_act = (x >= X_LO) && (x < X_HI);

  // Only the word-completing beat waits on a still-occupied output.
  assign stall = in_act && (pk_cnt == 3'd7) &&
                 raw_v && !dp.raw_pixel_ready;

  assign dp.dp_pixel_ready = active && !reset &&
                             !dp.dpdmahstart && !stall;

  assign acc = dp.dp_pixel_valid && dp.dp_pixel_ready;

  assign pair_bits = {lit(dp.dp_pixel_data[15:8], THRESH),
                      lit(dp.dp_pixel_data[39:32], THRESH)};

  assign px_unused = ^{dp.dp_pixel_data[47:40],
                       dp.dp_pixel_data[31:16],
                       dp.dp_pixel_data[7:0]};

  assign dp.raw_pixel_valid = raw_v;
  assign dp.raw_pixel_data  = raw_d;

  always_ff @(posedge dpclk) begin
    if (reset) begin
      active <= 1'b0;
      x      <= '0;
      pk_cnt <= '0;
      pack   <= '0;
      raw_v  <= 1'b0;
      raw_d  <= '0;
    end else begin
      if (raw_v && dp.raw_pixel_ready)
        raw_v <= 1'b0;
      if (dp.dpdmahstart) begin
        active <= 1'b1;
        x      <= '0;
        pk_cnt <= '0;
        pack   <= '0;
      end else if (acc) begin
        if (x == X_END) begin
          active <= 1'b0;
          x      <= '0;
        end else begin
          x <= x + 16'd2;
        end
        if (in_act) begin
          pack   <= {pack[11:0], pair_bits};
          pk_cnt <= pk_cnt + 3'd1;
          if (pk_cnt == 3'd7) begin
            raw_d <= {pack, pair_bits};
            raw_v <= 1'b1;
          end
        end
      end
    end
  end

`ifdef DPORT_PXPACK_ERRCNT_EN
  logic [7:0] err_q;

  always_ff @(posedge dpclk) begin
    if (reset)
      err_q <= '0;
    else if (dp.dpdmahstart && active &&
             (x != 16'd0) && (err_q != 8'hFF))
      err_q <= err_q + 8'd1;
  end

  assign err_cnt = err_q;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_dport_pxpack.sv
// Randomised bench for dport_pxpack: per-line reference words from pixel
// arrays, checked in order against every accepted output word.
module tb_dport_pxpack;
  import dport_pkg::*;

  localparam int         NB = LINE_TOT / 2;
  localparam int         NW = BLITH_DEF / 16;
  localparam logic [7:0] TH = 8'h80;
`ifdef DPORT_PXPACK_ERRCNT_EN
  localparam int ERR_EN = 1;
`else
  localparam int ERR_EN = 0;
`endif

  logic       dpclk = 1'b0;
  logic       reset;
  logic [7:0] err_cnt;

  dport_pxpack_if dif();

  dport_pxpack dut (
    .dpclk   (dpclk),
    .reset   (reset),
    .dp      (dif.slave),
    .err_cnt (err_cnt)
  );

  always #5 dpclk = ~dpclk;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [15:0] exp_q[$];
  int          words_seen;
  logic [15:0] first_word;
  logic        last_rdy;
  logic        last_acc;
  int          stall_left;
  int          stall_acc;
  bit          stall_arm;
  bit          in_stall;
  bit          rr_rand;
  bit          force0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: bound expired", tag);
  endtask

  // One clock: called at a falling edge, returns at the next one.
  task automatic cyc();
    logic [15:0] e;
    if (stall_arm && dif.raw_pixel_valid) begin
      stall_arm  = 1'b0;
      stall_left = 20;
    end
    if (force0) begin
      in_stall = 1'b0;
      dif.raw_pixel_ready = 1'b0;
    end else if (stall_left > 0) begin
      in_stall = 1'b1;
      stall_left--;
      dif.raw_pixel_ready = 1'b0;
    end else begin
      in_stall = 1'b0;
      dif.raw_pixel_ready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    #1;
    last_rdy = dif.dp_pixel_ready;
    last_acc = dif.dp_pixel_valid && last_rdy;
    if (in_stall && last_acc)
      stall_acc++;
    if (dif.raw_pixel_valid && dif.raw_pixel_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_word", exp_q.size(), 32'd1);
      end else begin
        e = exp_q.pop_front();
        if (words_seen == 0)
          first_word = dif.raw_pixel_data;
        words_seen++;
        chk("word", dif.raw_pixel_data, e);
      end
    end
    @(posedge dpclk);
    @(negedge dpclk);
  endtask

  // pat: 0 random, 1 bright/dark alternating, 2 threshold edge at x=PAD.
  // stl: 0 none, 1 hold sink off 20 cycles after first word, 2 sink off
  // for the last four beats.
  task automatic send_line(input int n, input int pat,
                           input bit hs, input int stl);
    logic [23:0] px[LINE_TOT];
    logic [15:0] wd;
    int          k;
    for (int i = 0; i < LINE_TOT; i++)
      px[i] = {8'h00, 8'($urandom_range(0, 255)), 8'h00};
    if (pat == 1)
      for (int i = 0; i < BLITH_DEF; i++)
        px[PAD_DEF + i] = (i % 2 == 0) ? BRIGHT : DARK;
    if (pat == 2) begin
      px[PAD_DEF]     = 24'h008000;
      px[PAD_DEF + 1] = 24'h007F00;
    end
    for (int w = 0; w < NW; w++) begin
      if (PAD_DEF + 16 * w + 16 <= 2 * n) begin
        for (int j = 0; j < 16; j++)
          wd[15 - j] = (px[PAD_DEF + 16 * w + j][15:8] >= TH);
        exp_q.push_back(wd);
      end
    end
    words_seen = 0;
    stall_acc  = 0;
    stall_arm  = (stl == 1);
    if (hs) begin
      dif.dpdmahstart    = 1'b1;
      dif.dp_pixel_valid = 1'b0;
      cyc();
      dif.dpdmahstart    = 1'b0;
    end
    for (int b = 0; b < n; b++) begin
      dif.dp_pixel_data = {px[2 * b + 1], px[2 * b]};
      force0 = (stl == 2) && (b >= n - 4);
      if (pat == 0 && stl == 0 && $urandom_range(0, 4) == 0) begin
        dif.dp_pixel_valid = 1'b0;
        cyc();
      end
      dif.dp_pixel_valid = 1'b1;
      k = 0;
      do begin
        cyc();
        k++;
      end while (!last_acc && k < 200);
      if (!last_acc) begin
        fail("beat_timeout");
        dif.dp_pixel_valid = 1'b0;
        force0 = 1'b0;
        return;
      end
    end
    dif.dp_pixel_valid = 1'b0;
    force0 = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    dif.dp_pixel_valid = 1'b0;
    while (exp_q.size() > 0 && k < 500) begin
      cyc();
      k++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset               = 1'b1;
    dif.dp_pixel_valid  = 1'b1;
    dif.dp_pixel_data   = '0;
    dif.dpdmahstart     = 1'b0;
    dif.raw_pixel_ready = 1'b0;
    rr_rand = 1'b0;
    force0  = 1'b0;
    stall_left = 0;
    stall_arm  = 1'b0;
    repeat (2) @(posedge dpclk);
    @(negedge dpclk);
    #1;
    chk("rst_raw_valid", dif.raw_pixel_valid, 32'd0);
    chk("rst_raw_data", dif.raw_pixel_data, 32'd0);
    chk("rst_dp_ready", dif.dp_pixel_ready, 32'd0);
    chk("rst_err_cnt", err_cnt, 32'd0);
    reset = 1'b0;
    @(negedge dpclk);
    #1;
    chk("idle_dp_ready", dif.dp_pixel_ready, 32'd0);
    dif.dp_pixel_valid = 1'b0;
    @(negedge dpclk);

    send_line(NB, 1, 1'b1, 0);
    dif.dp_pixel_valid = 1'b1;
    cyc();
    chk("rdy_after_line", last_rdy, 32'd0);
    drain();
    chk("alt_words", words_seen, NW);
    chk("alt_first", first_word, 32'h0000AAAA);

    rr_rand = 1'b1;
    send_line(NB, 2, 1'b1, 0);
    drain();
    chk("thr_bits", first_word[15:14], 32'd2);

    rr_rand = 1'b0;
    send_line(NB, 0, 1'b1, 1);
    chk("stall_beats", stall_acc, 32'd7);
    drain();
    chk("stall_words", words_seen, NW);

    rr_rand = 1'b1;
    send_line(200, 0, 1'b1, 0);
    send_line(NB, 0, 1'b1, 0);
    drain();
    chk("trunc_err", err_cnt, ERR_EN);

    send_line(300, 0, 1'b1, 2);
    chk("rst_pending_q", exp_q.size(), 32'd1);
    chk("rst_pending_v", dif.raw_pixel_valid, 32'd1);
    dif.raw_pixel_ready = 1'b0;
    dif.dp_pixel_valid  = 1'b1;
    reset = 1'b1;
    #1;
    chk("in_rst_ready", dif.dp_pixel_ready, 32'd0);
    @(posedge dpclk);
    @(negedge dpclk);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", dif.raw_pixel_valid, 32'd0);
    chk("mid_rst_ready", dif.dp_pixel_ready, 32'd0);
    chk("mid_rst_err", err_cnt, 32'd0);
    dif.dp_pixel_valid = 1'b0;
    exp_q.delete();
    @(negedge dpclk);

    send_line(NB - 1, 0, 1'b1, 0);
    dif.dp_pixel_data  = {$urandom(), $urandom()};
    dif.dp_pixel_valid = 1'b1;
    dif.dpdmahstart    = 1'b1;
    cyc();
    chk("hs_beat_ready", last_rdy, 32'd0);
    dif.dpdmahstart    = 1'b0;
    dif.dp_pixel_valid = 1'b0;
    cyc();
    chk("hs_active", last_rdy, 32'd1);
    send_line(NB, 0, 1'b0, 0);
    dif.dp_pixel_valid = 1'b1;
    cyc();
    chk("hs_line_end", last_rdy, 32'd0);
    drain();
    chk("hs_err", err_cnt, ERR_EN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
